ascon_ti_round_ctrl: RTL

- Iterative round engine for the 3-share threshold-implementation Ascon permutation; holds the shared 320-bit state.
- Each round, adds the round constant to share 0 and drives all three shares to the external TI substitution layer.
- Registers the substitution-layer outputs, which isolates glitches between the nonlinear and linear stages.
- Applies the Ascon linear diffusion layer independently to each share, iterates p^a/p^b, and reports completion through a start/done handshake.

---
 rtl/ascon_ti_round_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ascon_ti_round_ctrl.sv
// Iterative round controller for the 3-share threshold-implementation Ascon permutation.
// Optional remasking of the shares in every linear cycle is enabled by `define ASCON_TI_REMASK_EN.
module ascon_ti_round_ctrl #(
    parameter int MAX_ROUNDS = 12,
    parameter int SBOX_WAIT  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in_0,
    input  logic [319:0] state_in_1,
    input  logic [319:0] state_in_2,
    input  logic [319:0] sbox_y_0,
    input  logic [319:0] sbox_y_1,
    input  logic [319:0] sbox_y_2,
`ifdef ASCON_TI_REMASK_EN
    input  logic [319:0] rnd_a,
    input  logic [319:0] rnd_b,
`endif
    output logic [319:0] sbox_x_0,
    output logic [319:0] sbox_x_1,
    output logic [319:0] sbox_x_2,
    output logic [319:0] state_out_0,
    output logic [319:0] state_out_1,
    output logic [319:0] state_out_2,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, SUB, LIN, DONE} fsm_t;

    localparam int WW = (SBOX_WAIT > 0) ? $clog2(SBOX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SBOX_WAIT);
    localparam logic [3:0]    MAX_R     = 4'(MAX_ROUNDS);

    fsm_t          fsm_q, fsm_d;
    logic [3:0]    rnd_total_q, rnd_cnt_q, rounds_eff, rc_idx;
    logic [7:0]    rc;
    logic [WW-1:0] wait_q;
    logic          sub_last, last_round;
    logic [319:0]  st_q   [3];
    logic [319:0]  cap_q  [3];
    logic [319:0]  hold_q [3];
    logic [319:0]  mask   [3];

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] lin_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign rounds_eff = (rounds == 4'd0 || rounds > MAX_R) ? MAX_R : rounds;
    assign rc_idx     = MAX_R - rnd_total_q + rnd_cnt_q;
    assign rc         = {4'hF - rc_idx, rc_idx};
    assign sub_last   = (wait_q == WAIT_LAST);
    assign last_round = (rnd_cnt_q == rnd_total_q - 4'd1);

`ifdef ASCON_TI_REMASK_EN
    // Sum of the three masks is zero, so the unshared state is preserved.
    assign mask[0] = rnd_a;
    assign mask[1] = rnd_b;
    assign mask[2] = rnd_a ^ rnd_b;
`else
    assign mask[0] = '0;
    assign mask[1] = '0;
    assign mask[2] = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: if (start) fsm_d = SUB;
            SUB:  if (sub_last) fsm_d = LIN;
            LIN:  fsm_d = last_round ? DONE : SUB;
            DONE: fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (fsm_q == SUB) || (fsm_q == LIN);
        done = (fsm_q == DONE);
    end

    // Outside SUB the substitution inputs are frozen so the nonlinear layer never toggles.
    always_comb begin
        if (fsm_q == SUB) begin
            sbox_x_0 = st_q[0] ^ {184'd0, rc, 128'd0};
            sbox_x_1 = st_q[1];
            sbox_x_2 = st_q[2];
        end else begin
            sbox_x_0 = hold_q[0];
            sbox_x_1 = hold_q[1];
            sbox_x_2 = hold_q[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_total_q <= '0;
            rnd_cnt_q   <= '0;
            wait_q      <= '0;
            for (int k = 0; k < 3; k++) begin
                st_q[k]   <= '0;
                cap_q[k]  <= '0;
                hold_q[k] <= '0;
            end
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        st_q[0]     <= state_in_0;
                        st_q[1]     <= state_in_1;
                        st_q[2]     <= state_in_2;
                        rnd_total_q <= rounds_eff;
                        rnd_cnt_q   <= '0;
                        wait_q      <= '0;
                    end
                end
                SUB: begin
                    hold_q[0] <= sbox_x_0;
                    hold_q[1] <= sbox_x_1;
                    hold_q[2] <= sbox_x_2;
                    if (sub_last) begin
                        cap_q[0] <= sbox_y_0;
                        cap_q[1] <= sbox_y_1;
                        cap_q[2] <= sbox_y_2;
                        wait_q   <= '0;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                LIN: begin
                    for (int k = 0; k < 3; k++) st_q[k] <= lin_layer(cap_q[k]) ^ mask[k];
                    rnd_cnt_q <= rnd_cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign state_out_0 = st_q[0];
    assign state_out_1 = st_q[1];
    assign state_out_2 = st_q[2];

endmodule
